// File: rtl/srff_bank_sched_if.sv
// Requester-side handshake bundle for srff_bank_sched: per-requester command
// fields in, one-hot grant/done pulses and the shared error pulse out.
interface srff_bank_sched_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
) ();
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    op;
    logic [IDXW*NREQ-1:0] idx;
    logic [NREQ-1:0]      wdat;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;

    modport master (output req, op, idx, wdat, input gnt, done, err);
    modport slave  (input req, op, idx, wdat, output gnt, done, err);
endinterface

// File: rtl/srff_bank_sched.sv
// Round-robin scheduler sharing one bank of set/reset D flip-flops among NREQ requesters.
// Optional error counter (err_cnt/err_clr) enabled by SRFF_BANK_SCHED_ERRCNT_EN.
module srff_bank_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             r,
    srff_bank_sched_if.slave bus,
    output logic [WIDTH-1:0] bank_s,
    output logic [WIDTH-1:0] bank_r,
    output logic [WIDTH-1:0] bank_d,
    input  logic [WIDTH-1:0] bank_q
`ifdef SRFF_BANK_SCHED_ERRCNT_EN
    ,
    input  logic             err_clr,
    output logic [7:0]       err_cnt
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, VERIFY} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [WIDTH-1:0]  shadow, shadow_nxt;
    logic [PW-1:0]     cmd_who;
    logic [1:0]        cmd_op;
    logic [IDXW-1:0]   cmd_idx;
    logic              cmd_oob;
    logic              exp_bit;

    logic              win_found;
    logic [PW-1:0]     win;
    logic [1:0]        sel_op;
    logic [IDXW-1:0]   sel_idx;
    logic              sel_wdat;
    logic              sel_oob;
    logic              sel_exp;
    logic              q_bit;

    logic [NREQ-1:0]   gnt_v;
    logic [NREQ-1:0]   done_v;
    logic              err_v;

    always_comb begin : arbiter
        int cand;
        win_found = 1'b0;
        win       = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win       = PW'(cand);
            end
        end
    end

    // The shadow commits on the grant edge so bank_d already carries the new
    // bit throughout ISSUE and the bank captures it on the ISSUE->VERIFY edge.
    always_comb begin : decode
        sel_op   = OP_LOAD;
        sel_idx  = '0;
        sel_wdat = 1'b0;
        for (int w = 0; w < NREQ; w++) begin
            if (int'(win) == w) begin
                sel_op   = bus.op[2*w +: 2];
                sel_idx  = bus.idx[IDXW*w +: IDXW];
                sel_wdat = bus.wdat[w];
            end
        end
        sel_oob    = int'(sel_idx) >= WIDTH;
        shadow_nxt = shadow;
        sel_exp    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(sel_idx) == i) begin
                case (sel_op)
                    OP_LOAD:   shadow_nxt[i] = sel_wdat;
                    OP_SET:    shadow_nxt[i] = 1'b1;
                    OP_CLEAR:  shadow_nxt[i] = 1'b0;
                    OP_TOGGLE: shadow_nxt[i] = ~shadow[i];
                    default:   shadow_nxt[i] = shadow[i];
                endcase
                sel_exp = shadow_nxt[i];
            end
        end
    end

    always_comb begin : fsm_comb
        state_nxt = state;
        gnt_v     = '0;
        done_v    = '0;
        err_v     = 1'b0;
        bank_s    = '0;
        bank_r    = r ? '1 : '0;
        q_bit     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(cmd_idx) == i) begin
                q_bit = bank_q[i];
            end
        end
        if (!r) begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state_nxt = ISSUE;
                        for (int w = 0; w < NREQ; w++) begin
                            gnt_v[w] = (int'(win) == w);
                        end
                    end
                end
                ISSUE: begin
                    state_nxt = VERIFY;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (int'(cmd_idx) == i) begin
                            bank_s[i] = (cmd_op == OP_SET);
                            bank_r[i] = (cmd_op == OP_CLEAR);
                        end
                    end
                end
                VERIFY: begin
                    state_nxt = IDLE;
                    for (int w = 0; w < NREQ; w++) begin
                        done_v[w] = (int'(cmd_who) == w);
                    end
                    err_v = cmd_oob || (q_bit != exp_bit);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign ptr_nxt  = (int'(cmd_who) == NREQ - 1) ? '0 : cmd_who + PW'(1);
    assign bank_d   = shadow;
    assign bus.gnt  = gnt_v;
    assign bus.done = done_v;
    assign bus.err  = err_v;

    always_ff @(posedge clk) begin
        if (r) begin
            state   <= IDLE;
            ptr     <= '0;
            shadow  <= '0;
            cmd_who <= '0;
            cmd_op  <= OP_LOAD;
            cmd_idx <= '0;
            cmd_oob <= 1'b0;
            exp_bit <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_found) begin
                cmd_who <= win;
                cmd_op  <= sel_op;
                cmd_idx <= sel_idx;
                cmd_oob <= sel_oob;
                exp_bit <= sel_exp;
                shadow  <= shadow_nxt;
            end
            if (state == VERIFY) begin
                ptr <= ptr_nxt;
            end
        end
    end

`ifdef SRFF_BANK_SCHED_ERRCNT_EN
    // A clear wins over a coincident error pulse.
    always_ff @(posedge clk) begin
        if (r || err_clr) begin
            err_cnt <= '0;
        end else if (err_v && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/srff_bank_sched.md
Name: srff_bank_sched

Overview:
- Scheduler that shares one bank of WIDTH set/reset D flip-flops among NREQ requesters.
- Each requester issues a single-bit command: LOAD, SET, CLEAR or TOGGLE.
- Commands are granted round-robin. The scheduler drives the bank's per-bit s/r/d lines, then reads back q to confirm the command took effect.
- Sits between control logic and the flip-flop bank. It is the only driver of the bank's s, r and d inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of flip-flops in the bank.
- IDXW, 3, bit-index width; must satisfy 2**IDXW >= WIDTH.

Ports:
- clk  in  1  clock; the bank is clocked by the same clk.
- r  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester command request; held until the matching done.
- op  in  2*NREQ  per-requester opcode: 00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE.
- idx  in  IDXW*NREQ  per-requester target bit index.
- wdat  in  NREQ  per-requester data bit, used by LOAD only.
- gnt  out  NREQ  one-hot, one-cycle pulse when a request is accepted.
- done  out  NREQ  one-hot, one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse, coincident with done, on a readback mismatch.
- bank_s  out  WIDTH  per-bit set strobe to the bank.
- bank_r  out  WIDTH  per-bit reset strobe to the bank.
- bank_d  out  WIDTH  per-bit data to the bank (shadow register).
- bank_q  in  WIDTH  bank outputs.

Behaviour:
- Reset (r=1 at a clk edge):
  - state=IDLE; rr pointer=0; shadow=0; gnt, done and err = 0; bank_s=0.
  - bank_r = all ones for every cycle r is high, so the bank clears.
  - Any in-flight command is dropped with no done.
- bank_d = shadow at all times. Untouched bits therefore reload their own value each clock.
- FSM states: IDLE, ISSUE, VERIFY.
- IDLE:
  - If any req bit is set, pick the first set req at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's op, idx and wdat.
  - Pulse gnt[winner]; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly one cycle):
  - LOAD: shadow[idx] <= wdat.
  - SET: bank_s[idx]=1 for this cycle; shadow[idx] <= 1.
  - CLEAR: bank_r[idx]=1 for this cycle; shadow[idx] <= 0.
  - TOGGLE: shadow[idx] <= ~shadow[idx].
  - Expected value is computed from the new shadow bit. Go to VERIFY.
- VERIFY:
  - Compare bank_q[idx] with the expected value.
  - Pulse done[winner]; pulse err if they differ.
  - pointer <= winner+1, mod NREQ. Return to IDLE.
- Latency: req sampled in IDLE -> gnt in the same cycle -> done 2 cycles later. Maximum one command per 3 cycles.
- Latched command: once granted, the command completes even if req drops. op/idx/wdat changes after gnt are ignored.
- Out-of-range idx (idx >= WIDTH): no bank strobe, shadow unchanged; VERIFY pulses done and err.
- bank_s and bank_r are never both high on the same bit. Outside reset, at most one bit of bank_s|bank_r is high per cycle.
- A requester must drop req in the cycle after its done, or it is considered for re-arbitration and is granted only when the round-robin order reaches it.
- Fairness: with all requesters active, each is granted once per NREQ commands.

Optional Feature:
- Macro: SRFF_BANK_SCHED_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt [7:0].
  - Counts err pulses, saturates at 255, cleared by r.
  - Adds input err_clr [1], which zeroes the count synchronously. If err_clr and err occur in the same cycle, the result is 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset release: r high 2 cycles -> bank_r=8'hFF during reset, bank_q=0, and no gnt, done or err afterwards with req=0.
- Single SET: requester 1, op=01, idx=5 -> gnt[1] at t, bank_s=8'h20 at t+1, done[1] at t+2, err=0, bank_q=8'h20.
- LOAD then TOGGLE: requester 0 LOADs idx=2 with wdat=1, then TOGGLEs idx=2 -> bank_q goes 8'h04 then 8'h00, two done pulses, err=0.
- Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0, gnt pulses 3 cycles apart.
- Fault injection: bench forces bank_q[3]=0 during CLEAR-then-SET of idx=3 by requester 2 -> err pulses with done[2]; err_cnt=1 when the macro is defined.
- Reset mid-operation: r asserted in the ISSUE cycle -> no done, state IDLE, shadow=0. The same req re-asserted is granted from pointer 0.
